// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, FSM states and misalignment helper for the load/store unit
package lsu_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, DONE} state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        return size == SZ_H ? off[0] : size == SZ_W ? |off[1:0] : size == SZ_D ? |off : 1'b0;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane extract with sign/zero extension and sub-doubleword store merge
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      off_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] merge_o
);

    logic [1:0]      size;
    logic            uns;
    logic [2:0]      off;
    logic [5:0]      sh;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] mask;

    always_comb begin
        size    = funct3_i[1:0];
        uns     = funct3_i[2];
        // low offset bits are dropped so an access never straddles the doubleword
        off     = size == SZ_D ? 3'b000 : size == SZ_W ? {off_i[2], 2'b00} :
                  size == SZ_H ? {off_i[2:1], 1'b0} : off_i;
        sh      = {off, 3'b000};
        lane    = rdata_i >> sh;
        mask    = (size == SZ_B ? 64'h0000_0000_0000_00FF : size == SZ_H ? 64'h0000_0000_0000_FFFF :
                   size == SZ_W ? 64'h0000_0000_FFFF_FFFF : {XLEN{1'b1}}) << sh;
        load_o  = size == SZ_B ? {{(XLEN-8){~uns & lane[7]}}, lane[7:0]} :
                  size == SZ_H ? {{(XLEN-16){~uns & lane[15]}}, lane[15:0]} :
                  size == SZ_W ? {{(XLEN-32){~uns & lane[31]}}, lane[31:0]} : lane;
        merge_o = (rdata_i & ~mask) | ((wdata_i << sh) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for 64-bit data memory, read-modify-write for narrow stores.
// Define LSU_MISALIGN_TRAP_EN to add the misaligned output and skip misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              misaligned,
`endif
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic [XLEN-1:0]   mwdata_q, mwdata_d;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   merged;
    logic              accept;
    logic              load_done;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              mis_q, mis_d;
`endif

    lsu_align u_align (
        .off_i    (addr_q[2:0]),
        .funct3_i (f3_q),
        .rdata_i  (rdata_q),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            f3_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            mwdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            f3_q     <= f3_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            mwdata_q <= mwdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= mis_d;
`endif
        end
    end

    always_comb begin
        accept   = reset && state_q == IDLE && req_valid && (req_read || req_write);
        state_d  = state_q;
        addr_d   = addr_q;
        f3_d     = f3_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        mwdata_d = mwdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d    = mis_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                addr_d   = req_addr;
                f3_d     = req_funct3;
                wdata_d  = req_wdata;
                we_d     = req_write;
                mwdata_d = req_write ? req_wdata : mwdata_q;
                // only full-doubleword stores can skip the read half of read-modify-write
                state_d  = req_write && req_funct3[1:0] == SZ_D ? WR_REQ : RD_REQ;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_d    = is_misaligned(req_funct3[1:0], req_addr[2:0]);
                if (mis_d) state_d = DONE;
`endif
            end
            RD_REQ:  state_d = mem_ready ? RD_WAIT : RD_REQ;
            RD_WAIT: if (mem_rvalid) begin
                rdata_d = mem_rdata;
                state_d = we_q ? MERGE : DONE;
            end
            MERGE: begin
                mwdata_d = merged;
                state_d  = WR_REQ;
            end
            WR_REQ:  state_d = mem_ready ? DONE : WR_REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign load_done  = state_q == DONE && !we_q && !mis_q;
    assign misaligned = state_q == DONE && mis_q;
`else
    assign load_done  = state_q == DONE && !we_q;
`endif

    assign stall      = accept || !(state_q == IDLE || state_q == DONE);
    assign resp_valid = state_q == DONE;
    assign resp_rdata = load_done ? load_data : '0;
    assign mem_valid  = state_q == RD_REQ || state_q == WR_REQ;
    assign mem_we     = state_q == WR_REQ;
    assign mem_addr   = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_wdata  = mwdata_q;

endmodule
